// File: rtl/ram64_arb_pkg.sv
// Shared constants and state encoding for the RAM_64 two-port arbiter.
package ram64_arb_pkg;

    localparam int RAM_AW = 6;
    localparam int RAM_DW = 16;

    localparam int P0 = 0;
    localparam int P1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/ram64_port_arbiter_rr_pick2.sv
// Combinational two-way picker: single requester wins outright, ties go to
// port 0 under fixed priority, otherwise to the port that did not win last.
module rr_pick2 (
    input  logic [1:0] REQ,
    input  logic       LAST,
    input  logic       FIXED_PRIO,
    output logic [1:0] WIN,
    output logic       VALID
);

    always_comb begin
        WIN = '0;
        unique case (REQ)
            2'b01:   WIN = 2'b01;
            2'b10:   WIN = 2'b10;
            2'b11:   WIN = (FIXED_PRIO || LAST) ? 2'b01 : 2'b10;
            default: WIN = '0;
        endcase
    end

    assign VALID = |REQ;

endmodule

// File: rtl/ram64_port_arbiter.sv
// Arbiter/sequencer sharing the 64x16 single-port RAM between two requesters.
// Every RAM pin, grant, ACK and read-data output is driven from a register.
module ram64_port_arbiter
    import ram64_arb_pkg::*;
#(
    parameter int AW         = RAM_AW,
    parameter int DW         = RAM_DW,
    parameter int FIXED_PRIO = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          WE0,
    input  logic [AW-1:0] ADDR0,
    input  logic [DW-1:0] WDATA0,
    output logic          ACK0,
    output logic [DW-1:0] RDATA0,
    input  logic          REQ1,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK1,
    output logic [DW-1:0] RDATA1,
    output logic [1:0]    GNT,
    output logic          RAM_E,
    output logic          RAM_W,
    output logic          RAM_R,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_D,
    input  logic [DW-1:0] RAM_OUT
);

    state_t        r_state;
    logic          r_last;
    logic [1:0]    r_gnt;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_ram_e;
    logic          r_ram_w;
    logic          r_ram_r;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_d;

    logic [1:0]    w_win;
    logic          w_valid;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    rr_pick2 u_pick (
        .REQ        ({REQ1, REQ0}),
        .LAST       (r_last),
        .FIXED_PRIO (FIXED_PRIO != 0),
        .WIN        (w_win),
        .VALID      (w_valid)
    );

    assign w_sel   = w_win[P1];
    assign w_we    = w_sel ? WE1    : WE0;
    assign w_addr  = w_sel ? ADDR1  : ADDR0;
    assign w_wdata = w_sel ? WDATA1 : WDATA0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_gnt      <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_ram_e    <= 1'b0;
            r_ram_w    <= 1'b0;
            r_ram_r    <= 1'b0;
            r_ram_addr <= '0;
            r_ram_d    <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt      <= w_win;
                        r_last     <= w_sel;
                        r_ram_e    <= 1'b1;
                        r_ram_w    <= w_we;
                        r_ram_r    <= ~w_we;
                        r_ram_addr <= w_addr;
                        r_ram_d    <= w_wdata;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // RAM_OUT is valid for the whole access cycle; capture at its closing edge
                    if (r_gnt[P0] && r_ram_r) r_rdata0 <= RAM_OUT;
                    if (r_gnt[P1] && r_ram_r) r_rdata1 <= RAM_OUT;
                    r_ack0     <= r_gnt[P0];
                    r_ack1     <= r_gnt[P1];
                    r_gnt      <= '0;
                    r_ram_e    <= 1'b0;
                    r_ram_w    <= 1'b0;
                    r_ram_r    <= 1'b0;
                    r_ram_addr <= '0;
                    r_ram_d    <= '0;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign GNT      = r_gnt;
    assign ACK0     = r_ack0;
    assign ACK1     = r_ack1;
    assign RDATA0   = r_rdata0;
    assign RDATA1   = r_rdata1;
    assign RAM_E    = r_ram_e;
    assign RAM_W    = r_ram_w;
    assign RAM_R    = r_ram_r;
    assign RAM_ADDR = r_ram_addr;
    assign RAM_D    = r_ram_d;

endmodule

// File: tb/tb_ram64_port_arbiter.sv
// Bench for ram64_port_arbiter: directed vector table, corner sequences,
// a fixed-priority instance and randomized traffic against a transaction model.
module tb_ram64_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
    logic [5:0]  ADDR0 = '0, ADDR1 = '0;
    logic [15:0] WDATA0 = '0, WDATA1 = '0;
    logic        ACK0, ACK1, RAM_E, RAM_W, RAM_R;
    logic [15:0] RDATA0, RDATA1, RAM_D, RAM_OUT;
    logic [1:0]  GNT;
    logic [5:0]  RAM_ADDR;

    logic        fp_req0 = 1'b0, fp_req1 = 1'b0;
    logic        fp_ack0, fp_ack1, fp_e, fp_w, fp_r;
    logic [15:0] fp_rdata0, fp_rdata1, fp_d, fp_out;
    logic [1:0]  fp_gnt;
    logic [5:0]  fp_addr;

    logic [15:0] mem [64] = '{default: '0};

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ram64_port_arbiter #(.AW(6), .DW(16), .FIXED_PRIO(0)) u_dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0), .RDATA0(RDATA0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1), .RDATA1(RDATA1),
        .GNT(GNT), .RAM_E(RAM_E), .RAM_W(RAM_W), .RAM_R(RAM_R),
        .RAM_ADDR(RAM_ADDR), .RAM_D(RAM_D), .RAM_OUT(RAM_OUT)
    );

    ram64_port_arbiter #(.AW(6), .DW(16), .FIXED_PRIO(1)) u_fp (
        .CLK(CLK), .RST(RST),
        .REQ0(fp_req0), .WE0(1'b0), .ADDR0(6'd1), .WDATA0(16'h0000), .ACK0(fp_ack0), .RDATA0(fp_rdata0),
        .REQ1(fp_req1), .WE1(1'b0), .ADDR1(6'd2), .WDATA1(16'h0000), .ACK1(fp_ack1), .RDATA1(fp_rdata1),
        .GNT(fp_gnt), .RAM_E(fp_e), .RAM_W(fp_w), .RAM_R(fp_r),
        .RAM_ADDR(fp_addr), .RAM_D(fp_d), .RAM_OUT(fp_out)
    );

    // Behavioural RAM_64: combinational read, write on the rising edge.
    assign RAM_OUT = mem[RAM_ADDR];
    assign fp_out  = {10'b0, fp_addr};
    always @(posedge CLK) if (RAM_E && RAM_W) mem[RAM_ADDR] <= RAM_D;

    logic [60:0] w_act;
    assign w_act = {GNT, ACK0, ACK1, RAM_E, RAM_W, RAM_R, RAM_ADDR, RAM_D, RDATA0, RDATA1};

    task automatic chk(input string name, input logic [60:0] act, input logic [60:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        req0, we0;
        logic [5:0]  a0;
        logic [15:0] d0;
        logic        req1, we1;
        logic [5:0]  a1;
        logic [15:0] d1;
        logic [1:0]  gnt;
        logic        ack0, ack1, e, w, r;
        logic [15:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [5:0] a0, input logic [15:0] d0,
        input logic r1, input logic w1, input logic [5:0] a1, input logic [15:0] d1,
        input logic [1:0] g, input logic k0, input logic k1,
        input logic e, input logic w, input logic r, input logic [15:0] q0, input logic [15:0] q1);
        return '{req0: r0, we0: w0, a0: a0, d0: d0, req1: r1, we1: w1, a1: a1, d1: d1,
                 gnt: g, ack0: k0, ack1: k1, e: e, w: w, r: r, rd0: q0, rd1: q1};
    endfunction

    vec_t tbl [36];

    // Random-phase reference model state
    logic        rq [2];
    logic        rwe [2];
    logic [5:0]  ra [2];
    logic [15:0] rdt [2];
    logic        m_ack [2];
    logic [15:0] m_rd [2];
    logic [15:0] mmem [64];
    logic        m_last;
    logic [1:0]  e_gnt;
    logic        e_en, e_we, e_re;
    logic [5:0]  e_addr;
    logic [15:0] e_d;

    initial begin
        logic [5:0]  xa;
        logic [15:0] xd;
        int          fp_cnt;
        int          free_e, pg, pw;
        logic        pend, prd;
        logic [15:0] pval;

        // Directed table: inputs held across one edge, outputs checked after it.
        tbl[0]  = mk(1,1,6'd5,16'h00A5, 0,0,6'd0,16'h0,    2'b01,0,0,1,1,0, 16'h0,16'h0);
        tbl[1]  = mk(1,1,6'd5,16'h00A5, 0,0,6'd0,16'h0,    2'b00,1,0,0,0,0, 16'h0,16'h0);
        tbl[2]  = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h0,16'h0);
        tbl[3]  = mk(1,0,6'd5,16'h0,    0,0,6'd0,16'h0,    2'b01,0,0,1,0,1, 16'h0,16'h0);
        tbl[4]  = mk(1,0,6'd5,16'h0,    0,0,6'd0,16'h0,    2'b00,1,0,0,0,0, 16'h00A5,16'h0);
        tbl[5]  = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h00A5,16'h0);
        tbl[6]  = mk(1,1,6'd10,16'h7,   0,0,6'd0,16'h0,    2'b01,0,0,1,1,0, 16'h00A5,16'h0);
        tbl[7]  = mk(1,1,6'd10,16'h7,   0,0,6'd0,16'h0,    2'b00,1,0,0,0,0, 16'h00A5,16'h0);
        tbl[8]  = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h00A5,16'h0);
        tbl[9]  = mk(0,0,6'd0,16'h0,    1,1,6'd20,16'h9,   2'b10,0,0,1,1,0, 16'h00A5,16'h0);
        tbl[10] = mk(0,0,6'd0,16'h0,    1,1,6'd20,16'h9,   2'b00,0,1,0,0,0, 16'h00A5,16'h0);
        tbl[11] = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h00A5,16'h0);
        tbl[12] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b01,0,0,1,0,1, 16'h00A5,16'h0);
        tbl[13] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b00,1,0,0,0,0, 16'h7,16'h0);
        tbl[14] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b00,0,0,0,0,0, 16'h7,16'h0);
        tbl[15] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b10,0,0,1,0,1, 16'h7,16'h0);
        tbl[16] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b00,0,1,0,0,0, 16'h7,16'h9);
        tbl[17] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b00,0,0,0,0,0, 16'h7,16'h9);
        tbl[18] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b01,0,0,1,0,1, 16'h7,16'h9);
        tbl[19] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b00,1,0,0,0,0, 16'h7,16'h9);
        tbl[20] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b00,0,0,0,0,0, 16'h7,16'h9);
        tbl[21] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b10,0,0,1,0,1, 16'h7,16'h9);
        tbl[22] = mk(1,0,6'd10,16'h0,   1,0,6'd20,16'h0,   2'b00,0,1,0,0,0, 16'h7,16'h9);
        tbl[23] = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h7,16'h9);
        tbl[24] = mk(0,0,6'd0,16'h0,    1,1,6'd63,16'hFFFF,2'b10,0,0,1,1,0, 16'h7,16'h9);
        tbl[25] = mk(0,0,6'd0,16'h0,    1,1,6'd63,16'hFFFF,2'b00,0,1,0,0,0, 16'h7,16'h9);
        tbl[26] = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h7,16'h9);
        tbl[27] = mk(0,0,6'd0,16'h0,    1,1,6'd0,16'h1234, 2'b10,0,0,1,1,0, 16'h7,16'h9);
        tbl[28] = mk(0,0,6'd0,16'h0,    1,1,6'd0,16'h1234, 2'b00,0,1,0,0,0, 16'h7,16'h9);
        tbl[29] = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h7,16'h9);
        tbl[30] = mk(0,0,6'd0,16'h0,    1,0,6'd63,16'h0,   2'b10,0,0,1,0,1, 16'h7,16'h9);
        tbl[31] = mk(0,0,6'd0,16'h0,    1,0,6'd63,16'h0,   2'b00,0,1,0,0,0, 16'h7,16'hFFFF);
        tbl[32] = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h7,16'hFFFF);
        tbl[33] = mk(0,0,6'd0,16'h0,    1,0,6'd0,16'h0,    2'b10,0,0,1,0,1, 16'h7,16'hFFFF);
        tbl[34] = mk(0,0,6'd0,16'h0,    1,0,6'd0,16'h0,    2'b00,0,1,0,0,0, 16'h7,16'h1234);
        tbl[35] = mk(0,0,6'd0,16'h0,    0,0,6'd0,16'h0,    2'b00,0,0,0,0,0, 16'h7,16'h1234);

        // Reset then idle
        #1 chk("reset_async", w_act, '0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("idle_%0d", i), w_act, '0);
        end

        for (int i = 0; i < 36; i++) begin
            REQ0 = tbl[i].req0; WE0 = tbl[i].we0; ADDR0 = tbl[i].a0; WDATA0 = tbl[i].d0;
            REQ1 = tbl[i].req1; WE1 = tbl[i].we1; ADDR1 = tbl[i].a1; WDATA1 = tbl[i].d1;
            xa = tbl[i].gnt[0] ? tbl[i].a0 : (tbl[i].gnt[1] ? tbl[i].a1 : 6'd0);
            xd = tbl[i].gnt[0] ? tbl[i].d0 : (tbl[i].gnt[1] ? tbl[i].d1 : 16'd0);
            @(posedge CLK); #1;
            chk($sformatf("vec_%0d", i), w_act,
                {tbl[i].gnt, tbl[i].ack0, tbl[i].ack1, tbl[i].e, tbl[i].w, tbl[i].r, xa, xd, tbl[i].rd0, tbl[i].rd1});
        end

        // Reset in the middle of a write access: nothing committed, no ACK
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 6'd3; WDATA0 = 16'hBEEF; REQ1 = 1'b0;
        @(posedge CLK); #1;
        chk("midacc_write_on", 61'({RAM_E, RAM_W, GNT}), 61'(4'b1101));
        #3 RST = 1'b1;
        #1 chk("midacc_reset_clears", w_act, '0);
        REQ0 = 1'b0;
        @(posedge CLK); #1 RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("midacc_no_ack_%0d", i), w_act, '0);
        end
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 6'd3;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("midacc_read_addr3", 61'({ACK0, RDATA0}), 61'({1'b1, 16'h0000}));
        REQ0 = 1'b0;
        @(posedge CLK); #1;

        // Fixed priority: port 0 wins every time while both request
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        fp_req0 = 1'b1; fp_req1 = 1'b1; fp_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("fp_no_port1_%0d", i), 61'({fp_gnt[1], fp_ack1}), '0);
            if (fp_ack0) fp_cnt++;
        end
        chk("fp_ack0_count", 61'(fp_cnt), 61'(10));
        fp_req0 = 1'b0; fp_req1 = 1'b0;

        // Randomized traffic against a transaction-level model
        REQ0 = 1'b0; REQ1 = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rwe[p] = 1'b0; ra[p] = '0; rdt[p] = '0; m_ack[p] = 1'b0; m_rd[p] = '0;
        end
        for (int a = 0; a < 64; a++) mmem[a] = '0;
        m_last = 1'b1; free_e = 0; pg = 0; pw = 0; pend = 1'b0; prd = 1'b0; pval = '0;

        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && m_ack[p]) rq[p] = 1'b0;
                if (!rq[p] && $urandom_range(0, 99) < 45) begin
                    rq[p]  = 1'b1;
                    rwe[p] = 1'($urandom_range(0, 1));
                    ra[p]  = 6'(32 + $urandom_range(0, 15));
                    rdt[p] = 16'($urandom);
                end
            end
            REQ0 = rq[0]; WE0 = rwe[0]; ADDR0 = ra[0]; WDATA0 = rdt[0];
            REQ1 = rq[1]; WE1 = rwe[1]; ADDR1 = ra[1]; WDATA1 = rdt[1];

            e_gnt = '0; e_en = 1'b0; e_we = 1'b0; e_re = 1'b0; e_addr = '0; e_d = '0;
            m_ack[0] = 1'b0; m_ack[1] = 1'b0;
            if (pend && c == pg + 1) begin
                m_ack[pw] = 1'b1;
                if (prd) m_rd[pw] = pval;
                pend = 1'b0;
            end else if (c >= free_e && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) pw = (m_last == 1'b0) ? 1 : 0;
                else pw = rq[1] ? 1 : 0;
                e_gnt = (pw == 1) ? 2'b10 : 2'b01;
                e_en = 1'b1; e_we = rwe[pw]; e_re = ~rwe[pw];
                e_addr = ra[pw]; e_d = rdt[pw];
                prd = ~rwe[pw];
                if (rwe[pw]) mmem[ra[pw]] = rdt[pw];
                else pval = mmem[ra[pw]];
                pend = 1'b1; pg = c; free_e = c + 3; m_last = (pw == 1);
            end

            @(posedge CLK); #1;
            chk($sformatf("rand_%0d", c), w_act,
                {e_gnt, m_ack[0], m_ack[1], e_en, e_we, e_re, e_addr, e_d, m_rd[0], m_rd[1]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
